// File: rtl/code_lock_entry.sv
// Digit-code entry and lock controller: debounced push-buttons edit an entry buffer
// that is checked against a stored, reprogrammable code with a timed lockout after repeated failures.
module code_lock_entry #(
    parameter int N_DIGITS       = 4,
    parameter int DIGIT_BITS     = 4,
    parameter int DIGIT_MAX      = 9,
    parameter logic [N_DIGITS*DIGIT_BITS-1:0] DEFAULT_CODE = 16'h2405,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter int DEB_CYCLES     = 500_000,
    localparam int POS_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int TRY_W         = $clog2(MAX_TRIES + 1)
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    input  logic                           key_inc_n,
    input  logic                           key_next_n,
    input  logic                           key_set_n,
    output logic [N_DIGITS*DIGIT_BITS-1:0] entry,
    output logic [POS_W-1:0]               pos,
    output logic                           unlocked,
    output logic                           fail,
    output logic                           locked_out,
    output logic                           set_mode,
    output logic [TRY_W-1:0]               tries_left
);

    localparam int W     = N_DIGITS * DIGIT_BITS;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int LCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DEB_W-1:0]      DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LCK_W-1:0]      LCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [POS_W-1:0]      LAST_POS = POS_W'(N_DIGITS - 1);
    localparam logic [DIGIT_BITS-1:0] DMAX     = DIGIT_BITS'(DIGIT_MAX);
    localparam logic [TRY_W-1:0]      TRY_MAX  = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_ENTRY,
        S_CHECK,
        S_FAIL,
        S_LOCKOUT,
        S_OPEN,
        S_SET
    } state_t;

    logic [2:0]       keys;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       deb;
    logic [2:0]       press;
    logic [DEB_W-1:0] deb_cnt [3];

    assign keys = {key_set_n, key_next_n, key_inc_n};

    // The counter only runs while the synchronised level disagrees with the debounced one,
    // so any bounce back to the debounced level reloads it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            press <= '0;
            for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            for (int k = 0; k < 3; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                    press[k]   <= ~sync2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    logic ev_inc;
    logic ev_next;
    logic ev_set;

    assign ev_next = press[1];
    assign ev_inc  = press[0] & ~press[1];
    assign ev_set  = press[2];

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     code;
    logic [W-1:0]     code_next;
    logic [W-1:0]     entry_next;
    logic [POS_W-1:0] pos_next;
    logic [TRY_W-1:0] tries_next;
    logic [LCK_W-1:0] lock_cnt;
    logic [LCK_W-1:0] lock_next;
    logic [DIGIT_BITS-1:0] digit;
    logic [DIGIT_BITS-1:0] digit_inc;
    int               shift;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_ENTRY;
            entry      <= '0;
            pos        <= '0;
            code       <= DEFAULT_CODE;
            tries_left <= TRY_MAX;
            lock_cnt   <= '0;
            unlocked   <= 1'b0;
            fail       <= 1'b0;
            locked_out <= 1'b0;
            set_mode   <= 1'b0;
        end else begin
            state      <= state_next;
            entry      <= entry_next;
            pos        <= pos_next;
            code       <= code_next;
            tries_left <= tries_next;
            lock_cnt   <= lock_next;
            unlocked   <= (state_next == S_OPEN);
            fail       <= (state_next == S_FAIL);
            locked_out <= (state_next == S_LOCKOUT);
            set_mode   <= (state_next == S_SET);
        end
    end

    always_comb begin
        state_next = state;
        entry_next = entry;
        pos_next   = pos;
        code_next  = code;
        tries_next = tries_left;
        lock_next  = '0;
        shift      = (N_DIGITS - 1 - int'(pos)) * DIGIT_BITS;
        digit      = entry[shift +: DIGIT_BITS];
        digit_inc  = (digit == DMAX) ? '0 : digit + 1'b1;

        case (state)
            S_ENTRY, S_SET: begin
                if (ev_next) begin
                    if (pos != LAST_POS) begin
                        pos_next = pos + 1'b1;
                    end else if (state == S_ENTRY) begin
                        state_next = S_CHECK;
                    end else begin
                        code_next  = entry;
                        entry_next = '0;
                        pos_next   = '0;
                        state_next = S_ENTRY;
                    end
                end else if (ev_inc) begin
                    entry_next[shift +: DIGIT_BITS] = digit_inc;
                end
            end
            S_CHECK: begin
                if (entry == code) begin
                    tries_next = TRY_MAX;
                    state_next = S_OPEN;
                end else begin
                    tries_next = tries_left - 1'b1;
                    state_next = (tries_left == TRY_W'(1)) ? S_LOCKOUT : S_FAIL;
                end
            end
            S_FAIL: begin
                entry_next = '0;
                pos_next   = '0;
                state_next = S_ENTRY;
            end
            S_LOCKOUT: begin
                if (lock_cnt == LCK_LAST) begin
                    entry_next = '0;
                    pos_next   = '0;
                    tries_next = TRY_MAX;
                    state_next = S_ENTRY;
                end else begin
                    lock_next = lock_cnt + 1'b1;
                end
            end
            S_OPEN: begin
                // Relocking takes priority over entering programming mode.
                if (ev_next) begin
                    entry_next = '0;
                    pos_next   = '0;
                    state_next = S_ENTRY;
                end else if (ev_set) begin
                    entry_next = '0;
                    pos_next   = '0;
                    state_next = S_SET;
                end
            end
            default: state_next = S_ENTRY;
        endcase
    end

endmodule

// File: tb/tb_code_lock_entry.sv
// Directed bench for code_lock_entry with short debounce and lockout times.
module tb_code_lock_entry;

    logic        CLOCK_50   = 1'b0;
    logic        reset_n    = 1'b0;
    logic        key_inc_n  = 1'b1;
    logic        key_next_n = 1'b1;
    logic        key_set_n  = 1'b1;
    logic [15:0] entry;
    logic [1:0]  pos;
    logic        unlocked;
    logic        fail;
    logic        locked_out;
    logic        set_mode;
    logic [1:0]  tries_left;

    int compared    = 0;
    int mismatched  = 0;
    int fail_cycles = 0;
    int lock_cycles = 0;
    int f0;
    int l0;

    code_lock_entry #(
        .DEB_CYCLES     (4),
        .LOCKOUT_CYCLES (100)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .key_inc_n  (key_inc_n),
        .key_next_n (key_next_n),
        .key_set_n  (key_set_n),
        .entry      (entry),
        .pos        (pos),
        .unlocked   (unlocked),
        .fail       (fail),
        .locked_out (locked_out),
        .set_mode   (set_mode),
        .tries_left (tries_left)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (fail) fail_cycles++;
        if (locked_out) lock_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Holds the selected keys low for 10 cycles, then releases them for 10 cycles.
    task automatic applyStimulus(input bit inc, input bit nxt, input bit set);
        @(negedge CLOCK_50);
        key_inc_n  = ~inc;
        key_next_n = ~nxt;
        key_set_n  = ~set;
        repeat (10) @(negedge CLOCK_50);
        key_inc_n  = 1'b1;
        key_next_n = 1'b1;
        key_set_n  = 1'b1;
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic enterCode(input int a, input int b, input int c, input int e);
        int d[4];
        d = '{a, b, c, e};
        for (int i = 0; i < 4; i++) begin
            repeat (d[i]) applyStimulus(1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic doReset();
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic waitLockoutEnd();
        for (int i = 0; i < 200 && locked_out; i++) @(negedge CLOCK_50);
        checkOutput("lockout_end", locked_out, 0);
    endtask

    initial begin
        doReset();
        checkOutput("rst_entry", entry, 16'h0000);
        checkOutput("rst_pos", pos, 0);
        checkOutput("rst_unlocked", unlocked, 0);
        checkOutput("rst_fail", fail, 0);
        checkOutput("rst_locked", locked_out, 0);
        checkOutput("rst_set_mode", set_mode, 0);
        checkOutput("rst_tries", tries_left, 3);

        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("inc2_entry", entry, 16'h2000);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("next_pos", pos, 1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_final_entry", entry, 16'h2405);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("open_unlocked", unlocked, 1);
        checkOutput("open_tries", tries_left, 3);

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("relock_unlocked", unlocked, 0);
        checkOutput("relock_entry", entry, 16'h0000);
        checkOutput("relock_pos", pos, 0);

        f0 = fail_cycles;
        enterCode(2, 4, 0, 6);
        checkOutput("wrong1_fail_width", fail_cycles - f0, 1);
        checkOutput("wrong1_tries", tries_left, 2);
        checkOutput("wrong1_entry", entry, 16'h0000);
        checkOutput("wrong1_pos", pos, 0);
        checkOutput("wrong1_unlocked", unlocked, 0);

        enterCode(2, 4, 0, 6);
        checkOutput("wrong2_tries", tries_left, 1);
        l0 = lock_cycles;
        enterCode(2, 4, 0, 6);
        checkOutput("lockout_flag", locked_out, 1);
        checkOutput("lockout_tries", tries_left, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lockout_inc_ignored", entry, 16'h2406);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lockout_next_ignored", pos, 3);
        checkOutput("lockout_still", locked_out, 1);
        waitLockoutEnd();
        checkOutput("lockout_length", lock_cycles - l0, 100);
        checkOutput("post_lock_tries", tries_left, 3);
        checkOutput("post_lock_entry", entry, 16'h0000);
        checkOutput("post_lock_pos", pos, 0);

        enterCode(2, 4, 0, 5);
        checkOutput("reopen_unlocked", unlocked, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("set_mode_on", set_mode, 1);
        checkOutput("set_unlocked_off", unlocked, 0);
        checkOutput("set_entry_clear", entry, 16'h0000);
        enterCode(1, 1, 1, 1);
        checkOutput("commit_set_mode", set_mode, 0);
        checkOutput("commit_entry", entry, 16'h0000);
        checkOutput("commit_unlocked", unlocked, 0);
        f0 = fail_cycles;
        enterCode(2, 4, 0, 5);
        checkOutput("old_code_fail", fail_cycles - f0, 1);
        checkOutput("old_code_tries", tries_left, 2);
        enterCode(1, 1, 1, 1);
        checkOutput("new_code_unlocked", unlocked, 1);
        checkOutput("new_code_tries", tries_left, 3);
        applyStimulus(1'b0, 1'b1, 1'b0);

        repeat (9) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("digit_max", entry, 16'h9000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("digit_wrap", entry, 16'h0000);

        @(negedge CLOCK_50);
        key_inc_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        key_inc_n = 1'b1;
        repeat (15) @(negedge CLOCK_50);
        checkOutput("glitch_ignored", entry, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("both_pos", pos, 1);
        checkOutput("both_entry", entry, 16'h1000);

        doReset();
        checkOutput("abort_entry", entry, 16'h0000);
        checkOutput("abort_pos", pos, 0);
        enterCode(2, 4, 0, 5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        enterCode(1, 1, 1, 1);
        repeat (3) enterCode(2, 4, 0, 5);
        checkOutput("reprog_lockout", locked_out, 1);
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_locked", locked_out, 0);
        checkOutput("async_rst_tries", tries_left, 3);
        checkOutput("async_rst_entry", entry, 16'h0000);
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        enterCode(2, 4, 0, 5);
        checkOutput("default_code_restored", unlocked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/code_lock_entry.md
Name: code_lock_entry

Overview:
- Parametrised digit-code entry and lock controller for the DE1-SoC workshop designs.
- Inputs are active-low push-buttons:
  - inc steps the digit at the cursor.
  - next confirms the digit and moves the cursor right.
  - set reprograms the code, and only while unlocked.
- After the last digit, the entry is compared with a stored code.
- Counts failed attempts and enforces a timed lockout.
- Exports the entry buffer, cursor and status for the HEX/LEDR display logic.

Parameters:
- N_DIGITS, 4, number of code digits (≥1).
- DIGIT_BITS, 4, bits per digit.
- DIGIT_MAX, 9, largest digit value; inc wraps from DIGIT_MAX to 0.
- DEFAULT_CODE, 16'h2405, code loaded at reset; digit 0 in the MS nibble; width N_DIGITS*DIGIT_BITS.
- MAX_TRIES, 3, failed attempts allowed before lockout (≥1).
- LOCKOUT_CYCLES, 50_000_000, lockout duration in clocks.
- DEB_CYCLES, 500_000, stable-low clocks before a key press is accepted.
- Localparam POS_W = max(1, $clog2(N_DIGITS)).
- Localparam TRY_W = $clog2(MAX_TRIES+1).

Ports:
- CLOCK_50, input, 1, system clock; all logic on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- key_inc_n, input, 1, increment button, active-low, asynchronous to the clock.
- key_next_n, input, 1, next/confirm button, active-low.
- key_set_n, input, 1, program-new-code button, active-low.
- entry, output, N_DIGITS*DIGIT_BITS, current entry buffer; digit 0 in the MS field.
- pos, output, POS_W, cursor position.
- unlocked, output, 1, high in OPEN.
- fail, output, 1, one-cycle pulse on a wrong code.
- locked_out, output, 1, high in LOCKOUT.
- set_mode, output, 1, high in SET.
- tries_left, output, TRY_W, remaining attempts.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=ENTRY, entry=0, pos=0, code=DEFAULT_CODE, tries_left=MAX_TRIES.
  - All flags 0; debounce and lockout counters cleared.
  - Reset mid-entry or mid-lockout aborts immediately; a programmed code is lost.
- Key input conditioning, per key:
  - 2-FF synchroniser.
  - Debounce counter reloads on every level change of the synchronised key.
  - The debounced level changes after DEB_CYCLES consecutive equal samples.
  - A one-cycle press event fires on the debounced 1→0 transition. Releases generate nothing.
  - Holding a key gives exactly one event.
- Simultaneous events in one cycle: next has priority and inc is discarded. set is honoured only in OPEN.
- ENTRY:
  - inc: entry[pos] = (entry[pos]==DIGIT_MAX) ? 0 : entry[pos]+1.
  - next with pos<N_DIGITS-1: pos++; the new digit stays at its current value, which is 0 after a clear.
  - next with pos==N_DIGITS-1: go to CHECK.
- CHECK, exactly one cycle:
  - entry==code: go to OPEN, tries_left=MAX_TRIES.
  - Otherwise tries_left-1. If the result is 0, go to LOCKOUT; else go to FAIL.
- FAIL, one cycle:
  - fail=1.
  - entry=0, pos=0, then go to ENTRY.
- LOCKOUT:
  - locked_out=1; all key events ignored.
  - Counter runs 0..LOCKOUT_CYCLES-1.
  - On terminal count: go to ENTRY, entry=0, pos=0, tries_left=MAX_TRIES.
- OPEN:
  - unlocked=1.
  - next: relock; entry=0, pos=0, go to ENTRY.
  - set: entry=0, pos=0, go to SET.
  - inc is ignored.
- SET:
  - set_mode=1; unlocked=0.
  - inc/next edit as in ENTRY.
  - next at pos==N_DIGITS-1: code<=entry, entry=0, pos=0, go to ENTRY; the new code is effective on the next attempt.
- Latency:
  - Key press to output update is 2 (sync) + DEB_CYCLES + 1 clocks.
  - The final next reaches unlocked/fail one cycle later, through CHECK.
- Outputs are registered; no combinational path from the keys to the outputs.
- N_DIGITS=1: pos is constant 0; every next goes to CHECK (or commits, in SET).

Test Plan (bench overrides DEB_CYCLES=4, LOCKOUT_CYCLES=100; other parameters at default; keys held 10 cycles low, 10 high):
- Reset released, enter 2,4,0,5 (inc×2, next, inc×4, next, next, inc×5, next) → unlocked=1 one cycle after the final next is processed; tries_left=3.
- Enter 2,4,0,6 → fail pulses for 1 cycle; tries_left=2; entry=0 and pos=0.
- Three wrong codes → locked_out=1 for exactly 100 cycles; key presses ignored during that time; afterwards tries_left=3 and state ENTRY.
- From OPEN: press set, enter 1,1,1,1 → code committed. Entering 2,4,0,5 gives fail. Entering 1,1,1,1 gives unlocked.
- inc×10 on one digit → digit wraps to 0. 3-cycle glitch low on key_inc_n → no event. inc and next pressed on the same cycle → pos increments, digit unchanged.
- reset_n pulsed low mid-lockout and after reprogramming → locked_out=0 immediately; code back to 2405; tries_left=3.
